// File: rtl/ysyx_040750_mul_pkg.sv
// Shared constants and encodings for the sequential radix-4 Booth multiplier.
package ysyx_040750_mul_pkg;

  // Reference operand width; the other constants are derived from it.
  localparam int MUL_XLEN = 64;
  // Shifting multiplicand / accumulator width (65-bit operand product plus headroom).
  localparam int MUL_XW   = 2 * MUL_XLEN + 4;
  // Shifting multiplier width: {sign, ext65(b), 1'b0}.
  localparam int MUL_YW   = MUL_XLEN + 3;
  // Booth iterations needed to cover a 66-bit sign-extended multiplier.
  localparam int MUL_ITER = MUL_XLEN / 2 + 1;
  // Iteration counter width.
  localparam int CNT_W    = $clog2(MUL_ITER);

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // mul_signed = {a_signed, b_signed}; 2'b01 is handled like unsigned x unsigned.
  typedef enum logic [1:0] {
    MS_UU = 2'b00,
    MS_SU = 2'b10,
    MS_SS = 2'b11
  } mul_sign_e;

endpackage

// File: rtl/ysyx_040750_radix4_unit.sv
// One radix-4 Booth partial-product generator: booth triplet and aligned
// multiplicand in, ones-complement term P plus its +1 carry c out.
module ysyx_040750_radix4_unit
  import ysyx_040750_mul_pkg::*;
#(
  parameter int XW = MUL_XW
) (
  input  logic [2:0]    i_booth,
  input  logic [XW-1:0] i_x,
  output logic [XW-1:0] o_p,
  output logic          o_c
);

  logic [XW-1:0] w_mag;
  logic          w_neg;

  // Decode the triplet into a magnitude (0, X or 2X) and a negate flag.
  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (i_booth)
      3'b001, 3'b010: w_mag = i_x;
      3'b011:         w_mag = {i_x[XW-2:0], 1'b0};
      3'b100: begin
        w_mag = {i_x[XW-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = i_x;
        w_neg = 1'b1;
      end
      default: begin
        w_mag = '0;
        w_neg = 1'b0;
      end
    endcase
  end

  // Negation is split: invert here, the +1 travels out as o_c to be added by the accumulator.
  genvar gi;
  generate
    for (gi = 0; gi < XW; gi++) begin : g_inv
      assign o_p[gi] = w_mag[gi] ^ w_neg;
    end
  endgenerate

  assign o_c = w_neg;

endmodule

// File: rtl/ysyx_040750_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// One Booth triplet per cycle, up to 33 cycles, optional early finish when the
// remaining multiplier bits carry no more information.
module ysyx_040750_booth_mul_seq
  import ysyx_040750_mul_pkg::*;
#(
  parameter int EARLY_OUT = 1,
  parameter int XLEN      = MUL_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [1:0]      mul_signed,
  input  logic            mulw,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  // Internal widths follow XLEN, anchored on the package's 64-bit reference values.
  localparam int XW   = MUL_XW + 2 * (XLEN - MUL_XLEN);
  localparam int YW   = MUL_YW + (XLEN - MUL_XLEN);
  localparam int ITER = MUL_ITER + (XLEN - MUL_XLEN) / 2;
  localparam int CW   = (XLEN == MUL_XLEN) ? CNT_W : $clog2(ITER);

  mul_state_e r_state;
  mul_state_e w_state_next;
  logic       w_accept;

  logic [XW-1:0]   r_x;
  logic [XW-1:0]   r_acc;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic            r_mulw;
  logic [XLEN-1:0] r_res_hi;
  logic [XLEN-1:0] r_res_lo;

  // Operand conditioning for the accept cycle.
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_a_op;
  logic [XLEN-1:0] w_b_op;
  logic [XLEN:0]   w_a65;
  logic [XLEN:0]   w_b65;
  logic [XW-1:0]   w_x_init;
  logic [YW-1:0]   w_y_init;

  // Per-iteration datapath.
  logic [XW-1:0] w_p;
  logic          w_c;
  logic [XW-1:0] w_acc_next;
  logic [YW-1:0] w_y_next;
  logic          w_y_flat;
  logic          w_last;

  // Word ops see the low 32 bits sign-extended and always as signed values.
  assign w_a_sgn = mulw | (mul_signed == MS_SS) | (mul_signed == MS_SU);
  assign w_b_sgn = mulw | (mul_signed == MS_SS);
  assign w_a_op  = mulw ? {{(XLEN-32){multiplicand[31]}}, multiplicand[31:0]} : multiplicand;
  assign w_b_op  = mulw ? {{(XLEN-32){multiplier[31]}}, multiplier[31:0]} : multiplier;
  assign w_a65   = {w_a_sgn & w_a_op[XLEN-1], w_a_op};
  assign w_b65   = {w_b_sgn & w_b_op[XLEN-1], w_b_op};
  assign w_x_init = {{(XW-XLEN-1){w_a65[XLEN]}}, w_a65};
  assign w_y_init = {w_b65[XLEN], w_b65, 1'b0};

  ysyx_040750_radix4_unit #(
    .XW(XW)
  ) u_radix4 (
    .i_booth(r_y[2:0]),
    .i_x    (r_x),
    .o_p    (w_p),
    .o_c    (w_c)
  );

  assign w_acc_next = r_acc + w_p + {{(XW-1){1'b0}}, w_c};
  assign w_y_next   = {{2{r_y[YW-1]}}, r_y[YW-1:2]};
  // Once the shifted multiplier is all sign bits every remaining triplet decodes to 0.
  assign w_y_flat   = (w_y_next == '0) || (w_y_next == '1);
  assign w_last     = (r_cnt == CW'(ITER - 1)) || ((EARLY_OUT != 0) && w_y_flat);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides everything, including a same-cycle request.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mul_valid) begin
          w_state_next = ST_CALC;
          w_accept     = 1'b1;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) begin
      w_state_next = ST_IDLE;
      w_accept     = 1'b0;
    end
  end

  // Datapath: load on accept, iterate in CALC, capture the result on the last iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mulw   <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_x    <= w_x_init;
      r_y    <= w_y_init;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mulw <= mulw;
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_next;
      r_x   <= r_x << 2;
      r_y   <= w_y_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        if (r_mulw) begin
          r_res_hi <= '0;
          r_res_lo <= {{(XLEN-32){w_acc_next[31]}}, w_acc_next[31:0]};
        end else begin
          r_res_hi <= w_acc_next[2*XLEN-1:XLEN];
          r_res_lo <= w_acc_next[XLEN-1:0];
        end
      end
    end
  end

  assign mul_ready = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;

endmodule

// File: tb/tb_ysyx_040750_booth_mul_seq.sv
// Directed bench for the sequential Booth multiplier: one instance with early
// finish (_e) and one always running 33 iterations (_f), fed the same stimulus.
module tb_ysyx_040750_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mul_valid = 1'b0;
  logic [1:0]  mul_signed = 2'b00;
  logic        mulw = 1'b0;
  logic [63:0] multiplicand = '0;
  logic [63:0] multiplier = '0;
  logic        out_ready = 1'b0;

  logic        mul_ready_e, out_valid_e, mul_ready_f, out_valid_f;
  logic [63:0] hi_e, lo_e, hi_f, lo_f;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] got_hi_e, got_lo_e, got_hi_f, got_lo_f;
  int          lat_e, lat_f;

  always #5 clk = ~clk;

  ysyx_040750_booth_mul_seq #(.EARLY_OUT(1), .XLEN(64)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mul_valid(mul_valid), .mul_ready(mul_ready_e),
    .mul_signed(mul_signed), .mulw(mulw), .multiplicand(multiplicand), .multiplier(multiplier),
    .out_valid(out_valid_e), .out_ready(out_ready), .result_hi(hi_e), .result_lo(lo_e)
  );

  ysyx_040750_booth_mul_seq #(.EARLY_OUT(0), .XLEN(64)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mul_valid(mul_valid), .mul_ready(mul_ready_f),
    .mul_signed(mul_signed), .mulw(mulw), .multiplicand(multiplicand), .multiplier(multiplier),
    .out_valid(out_valid_f), .out_ready(out_ready), .result_hi(hi_f), .result_lo(lo_f)
  );

  // Full-width reference product from plain 128-bit multiplication.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sg, input logic w);
    logic [127:0] ax, bx, p;
    if (w) begin
      ax = {{96{a[31]}}, a[31:0]};
      bx = {{96{b[31]}}, b[31:0]};
    end else begin
      ax = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
      bx = (sg == 2'b11) ? {{64{b[63]}}, b} : {64'd0, b};
    end
    p = ax * bx;
    if (w) p = {64'd0, {32{p[31]}}, p[31:0]};
    return p;
  endfunction

  // Issue one op to both instances, scramble inputs after accept, wait for both results.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg, input logic w);
    @(negedge clk);
    multiplicand = a; multiplier = b; mul_signed = sg; mulw = w; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0; multiplicand = ~a; multiplier = ~b; mul_signed = ~sg; mulw = ~w;
    lat_e = -1; lat_f = -1;
    got_hi_e = 'x; got_lo_e = 'x; got_hi_f = 'x; got_lo_f = 'x;
    for (int k = 1; k <= 40 && (lat_e < 0 || lat_f < 0); k++) begin
      @(negedge clk);
      if (lat_e < 0 && out_valid_e === 1'b1) begin lat_e = k; got_hi_e = hi_e; got_lo_e = lo_e; end
      if (lat_f < 0 && out_valid_f === 1'b1) begin lat_f = k; got_hi_f = hi_f; got_lo_f = lo_f; end
    end
    if (lat_e < 0 || lat_f < 0) begin
      flush = 1'b1; @(negedge clk); flush = 1'b0;
    end else begin
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
    $display("[TB] op a=%h b=%h sg=%b w=%b -> hi=%h lo=%h lat_e=%0d lat_f=%0d",
             a, b, sg, w, got_hi_e, got_lo_e, lat_e, lat_f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mul_ready_e, out_valid_e, mul_ready_f, out_valid_f} !== 4'b1010) begin
      n_fail++; $display("FAIL reset_hs got=%b exp=1010", {mul_ready_e, out_valid_e, mul_ready_f, out_valid_f});
    end
    n_tests++;
    if ({hi_e, lo_e, hi_f, lo_f} !== 256'd0) begin
      n_fail++; $display("FAIL reset_result got hi_e=%h lo_e=%h exp 0", hi_e, lo_e);
    end
    rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    run_op(64'd3, 64'd5, 2'b11, 1'b0);
    n_tests++;
    if (got_lo_e !== 64'd15 || got_hi_e !== 64'd0 || got_lo_f !== 64'd15 || got_hi_f !== 64'd0) begin
      n_fail++; $display("FAIL mul_3x5 got lo_e=%h lo_f=%h hi_e=%h exp lo=f hi=0", got_lo_e, got_lo_f, got_hi_e);
    end
    n_tests++;
    if (lat_e !== 2 || lat_f !== 33) begin
      n_fail++; $display("FAIL lat_3x5 got e=%0d f=%0d exp e=2 f=33", lat_e, lat_f);
    end
    run_op(64'd123456789, 64'd0, 2'b11, 1'b0);
    n_tests++;
    if (got_lo_e !== 64'd0 || got_hi_e !== 64'd0 || got_lo_f !== 64'd0 || lat_e !== 1 || lat_f !== 33) begin
      n_fail++; $display("FAIL mul_b0 got lo=%h hi=%h lat_e=%0d lat_f=%0d exp 0 0 1 33", got_lo_e, got_hi_e, lat_e, lat_f);
    end
  endtask

  task automatic test_mulh();
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0);
    n_tests++;
    if (got_hi_f !== 64'd0 || got_lo_f !== 64'h8000_0000_0000_0000 ||
        got_hi_e !== 64'd0 || got_lo_e !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL mulh_min got hi_f=%h lo_f=%h hi_e=%h lo_e=%h exp hi=0 lo=8000..", got_hi_f, got_lo_f, got_hi_e, got_lo_e);
    end
    n_tests++;
    if (lat_f !== 33 || lat_e !== 1) begin
      n_fail++; $display("FAIL lat_mulh got e=%0d f=%0d exp e=1 f=33", lat_e, lat_f);
    end
  endtask

  task automatic test_unsigned();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0);
    n_tests++;
    if (got_hi_e !== 64'hFFFF_FFFF_FFFF_FFFE || got_lo_e !== 64'd1 || got_hi_f !== 64'hFFFF_FFFF_FFFF_FFFE || lat_e !== 33) begin
      n_fail++; $display("FAIL mulhu got hi=%h lo=%h lat_e=%0d exp hi=ff..fe lo=1 lat_e=33", got_hi_e, got_lo_e, lat_e);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0);
    n_tests++;
    if (got_hi_e !== 64'hFFFF_FFFF_FFFF_FFFF || got_lo_e !== 64'd1 || got_hi_f !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL mulhsu got hi=%h lo=%h exp hi=ff..ff lo=1", got_hi_e, got_lo_e);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0);
    n_tests++;
    if (got_hi_e !== 64'hFFFF_FFFF_FFFF_FFFE || got_lo_e !== 64'd1) begin
      n_fail++; $display("FAIL sign01 got hi=%h lo=%h exp hi=ff..fe lo=1", got_hi_e, got_lo_e);
    end
  endtask

  task automatic test_mulw();
    run_op(64'h0000_0000_7FFF_FFFF, 64'd2, 2'b11, 1'b1);
    n_tests++;
    if (got_lo_e !== 64'hFFFF_FFFF_FFFF_FFFE || got_hi_e !== 64'd0 || got_lo_f !== 64'hFFFF_FFFF_FFFF_FFFE || got_hi_f !== 64'd0) begin
      n_fail++; $display("FAIL mulw_ovf got lo=%h hi=%h exp lo=ff..fe hi=0", got_lo_e, got_hi_e);
    end
    n_tests++;
    if (lat_e < 1 || lat_e > 17 || lat_f !== 33) begin
      n_fail++; $display("FAIL lat_mulw got e=%0d f=%0d exp e<=17 f=33", lat_e, lat_f);
    end
    run_op(64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFB, 2'b00, 1'b1);
    n_tests++;
    if (got_lo_e !== 64'hFFFF_FFFF_FFFF_FFF1 || got_hi_e !== 64'd0 || lat_e > 17) begin
      n_fail++; $display("FAIL mulw_neg got lo=%h hi=%h lat=%0d exp lo=ff..f1 hi=0", got_lo_e, got_hi_e, lat_e);
    end
  endtask

  task automatic test_handshake();
    int seen;
    @(negedge clk);
    multiplicand = 64'd6; multiplier = 64'd7; mul_signed = 2'b11; mulw = 1'b0; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (out_valid_e === 1'b1) seen = 1;
    end
    n_tests++;
    if (seen == 0) begin
      n_fail++; $display("FAIL hs_timeout got out_valid_e=%b exp 1", out_valid_e);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid_e !== 1'b1 || mul_ready_e !== 1'b0 || lo_e !== 64'd42 || hi_e !== 64'd0) begin
        n_fail++; $display("FAIL hs_hold cyc=%0d got v=%b r=%b lo=%h exp v=1 r=0 lo=2a", k, out_valid_e, mul_ready_e, lo_e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid_e !== 1'b0 || mul_ready_e !== 1'b1) begin
      n_fail++; $display("FAIL hs_release got v=%b r=%b exp v=0 r=1", out_valid_e, mul_ready_e);
    end
    $display("[TB] handshake op 6*7 held 5 cycles then released");
    flush = 1'b1; @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    multiplicand = 64'h1234_5678_9ABC_DEF0; multiplier = 64'h4000_0000_0000_0001;
    mul_signed = 2'b11; mulw = 1'b0; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if ({mul_ready_e, out_valid_e, mul_ready_f, out_valid_f} !== 4'b1010) begin
      n_fail++; $display("FAIL flush_calc got=%b exp=1010", {mul_ready_e, out_valid_e, mul_ready_f, out_valid_f});
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_e === 1'b1 || out_valid_f === 1'b1) seen = 1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_no_out got seen=%0d exp 0", seen);
    end
    // flush and request in the same cycle: no accept (b=0 would otherwise finish in 1 cycle)
    multiplicand = 64'd9; multiplier = 64'd0; mul_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0; flush = 1'b0;
    n_tests++;
    if (mul_ready_e !== 1'b1 || mul_ready_f !== 1'b1) begin
      n_fail++; $display("FAIL flush_vs_valid got r_e=%b r_f=%b exp 1 1", mul_ready_e, mul_ready_f);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_e !== 1'b0) begin
      n_fail++; $display("FAIL flush_vs_valid_out got v=%b exp 0", out_valid_e);
    end
    $display("[TB] flush in CALC and flush with mul_valid done");
    run_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 2'b11, 1'b0);
    n_tests++;
    if (got_lo_e !== 64'hFFFF_FFFF_FFFF_FFD6 || got_hi_e !== 64'hFFFF_FFFF_FFFF_FFFF || got_lo_f !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      n_fail++; $display("FAIL after_flush got lo=%h hi=%h exp lo=ff..d6 hi=ff..ff", got_lo_e, got_hi_e);
    end
    // flush in DONE beats out_ready
    @(negedge clk);
    multiplicand = 64'd1; multiplier = 64'd1; mul_signed = 2'b11; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (out_valid_e === 1'b1) seen = 1;
    end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (seen == 0 || out_valid_e !== 1'b0 || mul_ready_e !== 1'b1 || mul_ready_f !== 1'b1) begin
      n_fail++; $display("FAIL flush_done got seen=%0d v=%b r=%b exp 1 0 1", seen, out_valid_e, mul_ready_e);
    end
    $display("[TB] flush in DONE checked");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    multiplicand = 64'd5; multiplier = 64'h7000_0000_0000_0000; mul_signed = 2'b11; mulw = 1'b0; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({mul_ready_e, out_valid_e, mul_ready_f, out_valid_f} !== 4'b1010 || {hi_e, lo_e, hi_f, lo_f} !== 256'd0) begin
      n_fail++; $display("FAIL reset_mid got hs=%b lo_e=%h hi_e=%h exp hs=1010 results 0",
                         {mul_ready_e, out_valid_e, mul_ready_f, out_valid_f}, lo_e, hi_e);
    end
    run_op(64'd2, 64'd3, 2'b11, 1'b0);
    n_tests++;
    if (got_lo_e !== 64'd6 || got_lo_f !== 64'd6 || got_hi_e !== 64'd0) begin
      n_fail++; $display("FAIL after_reset got lo_e=%h lo_f=%h exp 6", got_lo_e, got_lo_f);
    end
  endtask

  task automatic test_random();
    logic [63:0]  a, b;
    logic [1:0]   sg;
    logic         w;
    logic [127:0] exp_p;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(0, 15));
        3: a = 64'h8000_0000_0000_0000;
        default: ;
      endcase
      sg = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      exp_p = ref_prod(a, b, sg, w);
      run_op(a, b, sg, w);
      n_tests++;
      if ({got_hi_e, got_lo_e} !== exp_p || {got_hi_f, got_lo_f} !== exp_p || lat_f !== 33 || lat_e < 1) begin
        n_fail++; $display("FAIL rand%0d got e=%h f=%h lat_e=%0d lat_f=%0d exp %h", i, {got_hi_e, got_lo_e},
                           {got_hi_f, got_lo_f}, lat_e, lat_f, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mulh();
    test_unsigned();
    test_mulw();
    test_handshake();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
